// File: rtl/desc_word_sender.sv
// desc_word_sender
//
// Transmit side of the descriptor-load handshake that feeds the NCC
// processing-element grid. Each start command sends exactly one descriptor
// of WORDS_PER_DESC 32-bit words. The steps are:
//   - Accept a raw 8-bit pixel stream.
//   - Pack 4 pixels per word, with the first pixel in [31:24].
//   - Buffer the words in a small FIFO.
//   - Present the words one at a time with a ready/taken handshake.
//
// Build option:
//   DESC_ZERO_CLAMP_EN - when defined, a 0x00 pixel is packed as 0x01, so the
//                        downstream log2 never sees zero. When undefined,
//                        pixels are packed verbatim.
//
// Ports:
//   clk              clock
//   rst              asynchronous active-high reset
//   start            one-cycle pulse, begins a descriptor (honoured only when idle)
//   pix_in[7:0]      descriptor pixel
//   pix_valid        pix_in valid
//   pix_ready        pixel accepted when pix_valid & pix_ready
//   desc_data_out    packed word to the grid loader
//   desc_data_ready  desc_data_out valid, awaiting take
//   desc_data_taken  one-cycle pulse from the loader, consumes the current word
//   word_row[3:0]    row index of the word on desc_data_out
//   word_col[1:0]    column group of the word on desc_data_out
//   busy             descriptor transfer in progress
//   desc_done        one-cycle pulse after the last word is taken
//
// FSM states:
//   IDLE   | waiting for start
//   STREAM | accepting and packing pixels
//   DRAIN  | all pixels accepted, waiting for the loader to take the remaining words
//   DONE   | last word taken; desc_done pulse, counters cleared

module desc_word_sender #(
    parameter int WORDS_PER_DESC = 64,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [31:0] desc_data_out,
    output logic        desc_data_ready,
    input  logic        desc_data_taken,
    output logic [3:0]  word_row,
    output logic [1:0]  word_col,
    output logic        busy,
    output logic        desc_done
);

    localparam int PIX_TOTAL = 4 * WORDS_PER_DESC;
    localparam int PC_W      = $clog2(PIX_TOTAL + 1);
    localparam int WC_W      = ($clog2(WORDS_PER_DESC) > 6) ? $clog2(WORDS_PER_DESC) : 6;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int OCC_W     = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t            state;
    logic [1:0]        lane;
    logic [23:0]       pack;
    logic [PC_W-1:0]   pix_cnt;
    logic [WC_W-1:0]   word_cnt;

    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic              gap;

    logic              fifo_full;
    logic              take;
    logic              pix_acc;
    logic              push;
    logic              last_pix;
    logic              last_take;
    logic [7:0]        pix_val;

`ifdef DESC_ZERO_CLAMP_EN
    assign pix_val = (pix_in == 8'h00) ? 8'h01 : pix_in;
`else
    assign pix_val = pix_in;
`endif

    assign fifo_full       = (occ == OCC_W'(FIFO_DEPTH));
    // The cycle after a take is forced low so that the loader's single LOAD
    // cycle cannot consume the same word twice.
    assign desc_data_ready = (occ != '0) && !gap;
    assign take            = desc_data_taken && desc_data_ready;
    // A take in the same cycle frees a slot, so a full FIFO can still accept.
    assign pix_ready       = (state == STREAM) && (!fifo_full || take);
    assign pix_acc         = pix_valid && pix_ready;
    assign push            = pix_acc && (lane == 2'd3);
    assign last_pix        = (pix_cnt == PC_W'(PIX_TOTAL - 1));
    assign last_take       = take && (word_cnt == WC_W'(WORDS_PER_DESC - 1));

    assign desc_data_out   = desc_data_ready ? fifo_mem[rd_ptr] : 32'h0;
    assign word_col        = word_cnt[1:0];
    assign word_row        = word_cnt[5:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            desc_done <= 1'b0;
            lane      <= 2'd0;
            pack      <= 24'h0;
            pix_cnt   <= '0;
            word_cnt  <= '0;
        end else begin
            desc_done <= 1'b0;

            if (pix_acc) begin
                lane    <= lane + 2'd1;
                pix_cnt <= pix_cnt + PC_W'(1);
                case (lane)
                    2'd0:    pack[23:16] <= pix_val;
                    2'd1:    pack[15:8]  <= pix_val;
                    2'd2:    pack[7:0]   <= pix_val;
                    default: ;
                endcase
            end

            if (take) begin
                word_cnt <= word_cnt + WC_W'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= STREAM;
                        busy  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (pix_acc && last_pix) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_take) begin
                        state     <= DONE;
                        desc_done <= 1'b1;
                        word_cnt  <= '0;
                        pix_cnt   <= '0;
                        lane      <= 2'd0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Word FIFO. Pushes are gated by pix_ready, so a push never hits a full FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= 32'h0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            gap    <= 1'b0;
        end else begin
            gap <= take;
            if (push) begin
                fifo_mem[wr_ptr] <= {pack, pix_val};
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (take) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !take) begin
                occ <= occ + OCC_W'(1);
            end else if (!push && take) begin
                occ <= occ - OCC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_desc_word_sender.sv
module tb_desc_word_sender;

    localparam int WPD       = 64;
    localparam int DEPTH     = 4;
    localparam int PIX_TOTAL = 4 * WPD;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        pix_ready;
    logic [31:0] desc_data_out;
    logic        desc_data_ready;
    logic        desc_data_taken;
    logic [3:0]  word_row;
    logic [1:0]  word_col;
    logic        busy;
    logic        desc_done;

    desc_word_sender #(.WORDS_PER_DESC(WPD), .FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .pix_in          (pix_in),
        .pix_valid       (pix_valid),
        .pix_ready       (pix_ready),
        .desc_data_out   (desc_data_out),
        .desc_data_ready (desc_data_ready),
        .desc_data_taken (desc_data_taken),
        .word_row        (word_row),
        .word_col        (word_col),
        .busy            (busy),
        .desc_done       (desc_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: a transaction view of one descriptor transfer.
    logic [7:0]  pix_src [256];
    logic [7:0]  pbuf [$];
    logic [31:0] q [$];
    bit          active, done_now, gap_m;
    int          pix_acc, taken, done_cnt, dut_done_cnt;
    logic [31:0] first_word, last_word;

    // Stimulus knobs.
    int vprob  = 100;
    int lat    = 0;
    bit hold_tk = 0;
    int age    = 0;

    function automatic logic [7:0] clamp(input logic [7:0] p);
`ifdef DESC_ZERO_CLAMP_EN
        return (p == 8'h00) ? 8'h01 : p;
`else
        return p;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        pbuf.delete();
        active   = 0;
        done_now = 0;
        gap_m    = 0;
        pix_acc  = 0;
        taken    = 0;
        age      = 0;
    endtask

    task automatic cycle(input logic st);
        logic       pv, tk, exp_rdy, exp_prdy, tk_ok, acc;
        logic [7:0] px;
        bit         was_active;
        @(negedge clk);
        if (desc_data_ready) age++;
        else age = 0;
        tk = hold_tk || (lat >= 0 && desc_data_ready && age > lat);
        pv = ($urandom_range(99) < vprob);
        px = pv ? pix_src[pix_acc % 256] : 8'($urandom);
        start           = st;
        pix_valid       = pv;
        pix_in          = px;
        desc_data_taken = tk;
        #1;
        exp_rdy  = (q.size() > 0) && !gap_m;
        exp_prdy = active && !done_now && (pix_acc < PIX_TOTAL) &&
                   ((q.size() < DEPTH) || (tk && exp_rdy));
        chk("ready", desc_data_ready, exp_rdy);
        chk("pix_ready", pix_ready, exp_prdy);
        chk("busy", busy, active);
        chk("desc_done", desc_done, done_now);
        if (desc_done) dut_done_cnt++;
        if (exp_rdy) begin
            chk("data", desc_data_out, q[0]);
            chk("row", word_row, (taken / 4) % 16);
            chk("col", word_col, taken % 4);
        end
        tk_ok = tk && exp_rdy;
        acc   = pv && exp_prdy;
        was_active = active;
        if (done_now) begin
            active   = 0;
            done_now = 0;
            pix_acc  = 0;
            taken    = 0;
            done_cnt++;
        end
        if (tk_ok) begin
            if (taken == 0) first_word = q[0];
            last_word = q[0];
            void'(q.pop_front());
            taken++;
            if (taken == WPD) done_now = 1;
        end
        gap_m = tk_ok;
        if (acc) begin
            pbuf.push_back(clamp(px));
            pix_acc++;
            if (pbuf.size() == 4) begin
                q.push_back({pbuf[0], pbuf[1], pbuf[2], pbuf[3]});
                pbuf.delete();
            end
        end
        if (st && !was_active) active = 1;
    endtask

    task automatic run_done(input string tag, input int budget, input bit rand_start);
        int d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) begin
            cycle(rand_start && ($urandom_range(15) == 0));
        end
        chk({tag, "_complete"}, done_cnt, d0 + 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_data"}, desc_data_out, 32'h0);
        chk({tag, "_ready"}, desc_data_ready, 1'b0);
        chk({tag, "_pix_ready"}, pix_ready, 1'b0);
        chk({tag, "_row"}, word_row, 4'h0);
        chk({tag, "_col"}, word_col, 2'h0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, desc_done, 1'b0);
    endtask

    task automatic random_pixels();
        for (int i = 0; i < 256; i++) pix_src[i] = 8'($urandom);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        pix_valid = 1'b0;
        pix_in = 8'h00;
        desc_data_taken = 1'b0;
        dut_done_cnt = 0;
        done_cnt = 0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check_outputs_zero("por");
        rst = 1'b0;

        // Ramp 0x00..0xFF, loader takes 2 cycles after ready.
        for (int i = 0; i < 256; i++) pix_src[i] = 8'(i);
        vprob = 100; lat = 2; hold_tk = 0;
        cycle(1);
        run_done("ramp", 3000, 0);
`ifdef DESC_ZERO_CLAMP_EN
        chk("ramp_word0", first_word, 32'h01010203);
`else
        chk("ramp_word0", first_word, 32'h00010203);
`endif
        chk("ramp_word63", last_word, 32'hFCFDFEFF);
        repeat (3) cycle(0);
        chk("ramp_done_pulses", dut_done_cnt, 1);

        // Loader stalls: FIFO fills and pixel intake stops at 16 pixels.
        random_pixels();
        lat = -1;
        cycle(1);
        repeat (40) cycle(0);
        chk("stall_pixels", pix_acc, 16);
        lat = 0;
        run_done("stall", 3000, 0);

        // Taken held high throughout, random valid gaps, stray start pulses.
        random_pixels();
        vprob = 70; hold_tk = 1;
        cycle(1);
        run_done("hold", 4000, 1);
        hold_tk = 0;
        repeat (2) cycle(0);
        chk("hold_done_pulses", dut_done_cnt, 3);

        // Reset after 100 pixels, then a fresh descriptor.
        random_pixels();
        vprob = 100; lat = 1;
        cycle(1);
        for (int i = 0; i < 1000 && pix_acc < 100; i++) cycle(0);
        chk("pre_reset_pixels", pix_acc, 100);
        @(negedge clk);
        #2;
        rst = 1'b1;
        start = 1'b0; pix_valid = 1'b0; desc_data_taken = 1'b0;
        #1;
        check_outputs_zero("abort");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        random_pixels();
        cycle(1);
        run_done("restart", 3000, 0);
        chk("restart_done_pulses", dut_done_cnt, 4);

        // Zero-clamp pattern in word 0.
        random_pixels();
        pix_src[0] = 8'h00; pix_src[1] = 8'h05; pix_src[2] = 8'h00; pix_src[3] = 8'hFF;
        vprob = 60; lat = $urandom_range(3);
        cycle(1);
        run_done("clamp", 4000, 0);
`ifdef DESC_ZERO_CLAMP_EN
        chk("clamp_word0", first_word, 32'h010501FF);
`else
        chk("clamp_word0", first_word, 32'h000500FF);
`endif

        // Random descriptors.
        for (int d = 0; d < 2; d++) begin
            random_pixels();
            vprob = $urandom_range(40, 100);
            lat   = $urandom_range(4);
            cycle(1);
            run_done("rand", 5000, 1);
        end
        repeat (3) cycle(0);
        chk("total_done_pulses", dut_done_cnt, 7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
